// File: rtl/mem_bist_if.sv
// mem_bist_if: request/response bus between the BIST engine and a memory controller
interface mem_bist_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 24
);
    logic              stb;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] din;
    logic [DATA_W-1:0] dout;
    logic              busy;
    logic              done;
    modport master (output stb, we, addr, din, input dout, busy, done);
    modport slave  (input stb, we, addr, din, output dout, busy, done);
endinterface

// File: rtl/mem_bist.sv
// mem_bist: write-then-read-compare memory self test over a pattern-generated word range
module mem_bist #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 24,
    parameter int ADDR_STEP = 4,
    parameter int CNT_W     = 20
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [1:0]        i_mode,
    input  logic [DATA_W-1:0] i_seed,
    input  logic [ADDR_W-1:0] i_base_addr,
    input  logic [CNT_W-1:0]  i_num_words,
    input  logic              i_stop_on_fail,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_pass,
    output logic [CNT_W-1:0]  o_err_count,
    output logic [ADDR_W-1:0] o_fail_addr,
    output logic [DATA_W-1:0] o_fail_exp,
    output logic [DATA_W-1:0] o_fail_got,
    mem_bist_if.master        mem
);
    typedef enum logic [2:0] {IDLE, WAIT_RDY, WR_REQ, WR_WAIT, RD_REQ, RD_WAIT, CMP, FINISH} state_t;

    localparam logic [DATA_W-1:0] ALT_55 = DATA_W'({(DATA_W + 1) / 2{2'b01}});

    state_t            state_q, state_d;
    logic [1:0]        mode_q, mode_d;
    logic [DATA_W-1:0] seed_q, seed_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  num_q, num_d;
    logic [CNT_W-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0]  err_q, err_d;
    logic              stop_q, stop_d;
    logic              pass_q, pass_d;
    logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
    logic [DATA_W-1:0] fail_exp_q, fail_exp_d;
    logic [DATA_W-1:0] fail_got_q, fail_got_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [DATA_W-1:0] pat;
    logic              last;
    logic              mismatch;

    assign last     = (idx_q == num_q - CNT_W'(1));
    assign mismatch = (rdata_q != pat);

    // pattern for the current word, derived from the latched mode and word index/address
    always_comb begin
        pat = (mode_q == 2'd0) ? seed_q + DATA_W'(idx_q) :
              (mode_q == 2'd1) ? DATA_W'(addr_q) :
              (mode_q == 2'd2) ? DATA_W'(1) << (idx_q % CNT_W'(DATA_W)) :
              idx_q[0] ? ALT_55 : ~ALT_55;
    end

    // run sequencing: write pass, read/compare pass, result capture
    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        seed_d      = seed_q;
        base_d      = base_q;
        addr_d      = addr_q;
        num_d       = num_q;
        idx_d       = idx_q;
        err_d       = err_q;
        stop_d      = stop_q;
        pass_d      = pass_q;
        fail_addr_d = fail_addr_q;
        fail_exp_d  = fail_exp_q;
        fail_got_d  = fail_got_q;
        rdata_d     = rdata_q;
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    mode_d      = i_mode;
                    seed_d      = i_seed;
                    base_d      = i_base_addr;
                    addr_d      = i_base_addr;
                    num_d       = i_num_words;
                    stop_d      = i_stop_on_fail;
                    idx_d       = '0;
                    err_d       = '0;
                    pass_d      = 1'b0;
                    fail_addr_d = '0;
                    fail_exp_d  = '0;
                    fail_got_d  = '0;
                    state_d     = (i_num_words == '0) ? FINISH : WAIT_RDY;
                end
            end
            WAIT_RDY: state_d = mem.busy ? WAIT_RDY : WR_REQ;
            WR_REQ:   state_d = mem.busy ? WR_REQ : WR_WAIT;
            WR_WAIT: begin
                if (mem.done) begin
                    state_d = last ? RD_REQ : WR_REQ;
                    idx_d   = last ? '0 : idx_q + CNT_W'(1);
                    addr_d  = last ? base_q : addr_q + ADDR_W'(ADDR_STEP);
                end
            end
            RD_REQ: state_d = mem.busy ? RD_REQ : RD_WAIT;
            RD_WAIT: begin
                if (mem.done) begin
                    rdata_d = mem.dout;
                    state_d = CMP;
                end
            end
            CMP: begin
                if (mismatch) begin
                    err_d = (&err_q) ? err_q : err_q + CNT_W'(1);
                    if (err_q == '0) begin
                        fail_addr_d = addr_q;
                        fail_exp_d  = pat;
                        fail_got_d  = rdata_q;
                    end
                end
                state_d = ((mismatch && stop_q) || last) ? FINISH : RD_REQ;
                idx_d   = idx_q + CNT_W'(1);
                addr_d  = addr_q + ADDR_W'(ADDR_STEP);
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (state_d == FINISH) pass_d = (err_d == '0);
    end

    // state register with asynchronous clear
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= IDLE;
            mode_q      <= '0;
            seed_q      <= '0;
            base_q      <= '0;
            addr_q      <= '0;
            num_q       <= '0;
            idx_q       <= '0;
            err_q       <= '0;
            stop_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_addr_q <= '0;
            fail_exp_q  <= '0;
            fail_got_q  <= '0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            seed_q      <= seed_d;
            base_q      <= base_d;
            addr_q      <= addr_d;
            num_q       <= num_d;
            idx_q       <= idx_d;
            err_q       <= err_d;
            stop_q      <= stop_d;
            pass_q      <= pass_d;
            fail_addr_q <= fail_addr_d;
            fail_exp_q  <= fail_exp_d;
            fail_got_q  <= fail_got_d;
            rdata_q     <= rdata_d;
        end
    end

    assign mem.stb     = ((state_q == WR_REQ) || (state_q == RD_REQ)) && !mem.busy;
    assign mem.we      = (state_q == WR_REQ) || (state_q == WR_WAIT);
    assign mem.addr    = addr_q;
    assign mem.din     = pat;
    assign o_busy      = (state_q != IDLE);
    assign o_done      = (state_q == FINISH);
    assign o_pass      = pass_q;
    assign o_err_count = err_q;
    assign o_fail_addr = fail_addr_q;
    assign o_fail_exp  = fail_exp_q;
    assign o_fail_got  = fail_got_q;
endmodule

// File: tb/tb_mem_bist.sv
// tb_mem_bist: directed and randomized checks of mem_bist against a behavioural memory and run model
module tb_mem_bist;
    typedef struct packed {logic we; logic [23:0] a; logic [31:0] d;} txn_t;

    logic        clk = 0;
    logic        rst = 0;
    logic        start = 0, start_b = 0, sf = 0;
    logic [1:0]  md = 0;
    logic [31:0] sd = 0;
    logic [23:0] ba = 0;
    logic [7:0]  ba_b = 0;
    logic [19:0] nw = 0;
    logic        busy_o, done_o, pass_o, busy_b, done_b, pass_b;
    logic [19:0] err_o, err_b;
    logic [23:0] faddr_o;
    logic [7:0]  faddr_b;
    logic [31:0] fexp_o, fgot_o, fexp_b, fgot_b;

    always #5 clk = ~clk;

    mem_bist_if #(.DATA_W(32), .ADDR_W(24)) bus ();
    mem_bist_if #(.DATA_W(32), .ADDR_W(8))  bus_b ();

    mem_bist dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_mode(md), .i_seed(sd),
        .i_base_addr(ba), .i_num_words(nw), .i_stop_on_fail(sf),
        .o_busy(busy_o), .o_done(done_o), .o_pass(pass_o), .o_err_count(err_o),
        .o_fail_addr(faddr_o), .o_fail_exp(fexp_o), .o_fail_got(fgot_o), .mem(bus)
    );

    mem_bist #(.ADDR_W(8)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_start(start_b), .i_mode(md), .i_seed(sd),
        .i_base_addr(ba_b), .i_num_words(nw), .i_stop_on_fail(sf),
        .o_busy(busy_b), .o_done(done_b), .o_pass(pass_b), .o_err_count(err_b),
        .o_fail_addr(faddr_b), .o_fail_exp(fexp_b), .o_fail_got(fgot_b), .mem(bus_b)
    );

    int          checks = 0, errors = 0;
    int          lat = 3, pend = 0, pend_b = 0, prot_err = 0;
    logic        force_busy = 0, fault_en = 0;
    logic [23:0] fault_a = 0;
    logic [31:0] fault_mask = 0, fault_val = 0;
    logic [31:0] mem [logic [23:0]];
    logic [31:0] mem_b [logic [7:0]];
    txn_t        log_q[$], log_b[$], exp_q[$];
    txn_t        cur, cur_b;
    int          exp_err;
    logic [23:0] exp_faddr;
    logic [31:0] exp_fexp, exp_fgot;

    initial begin
        bus.busy = 0; bus.done = 0; bus.dout = 0;
        bus_b.busy = 0; bus_b.done = 0; bus_b.dout = 0;
    end

    // controller model A: accepts stb, answers after lat cycles, optional stuck bits on reads
    always @(negedge clk) begin
        if (rst) begin
            pend = 0; bus.busy = 0; bus.done = 0;
        end else begin
            bus.done = 0;
            if (pend > 0) begin
                if (bus.stb || bus.we !== cur.we || bus.addr !== cur.a || (cur.we && bus.din !== cur.d)) prot_err++;
                pend--;
                if (pend == 0) begin
                    bus.done = 1;
                    bus.busy = force_busy;
                    if (cur.we) mem[cur.a] = cur.d;
                    else begin
                        bus.dout = mem.exists(cur.a) ? mem[cur.a] : 32'h0;
                        if (fault_en && cur.a == fault_a) bus.dout = (bus.dout & ~fault_mask) | (fault_val & fault_mask);
                    end
                end else bus.busy = 1;
            end else if (bus.stb) begin
                cur = {bus.we, bus.addr, bus.we ? bus.din : 32'h0};
                log_q.push_back(cur);
                pend = lat;
            end else bus.busy = force_busy;
        end
    end

    // controller model B (8-bit addresses): single-cycle answer, never busy
    always @(negedge clk) begin
        bus_b.done = 0;
        if (rst) pend_b = 0;
        else if (pend_b > 0) begin
            pend_b = 0;
            bus_b.done = 1;
            if (cur_b.we) mem_b[cur_b.a[7:0]] = cur_b.d;
            else bus_b.dout = mem_b.exists(cur_b.a[7:0]) ? mem_b[cur_b.a[7:0]] : 32'h0;
        end else if (bus_b.stb) begin
            cur_b = {bus_b.we, 16'h0, bus_b.addr, bus_b.we ? bus_b.din : 32'h0};
            log_b.push_back(cur_b);
            pend_b = 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pat(input logic [1:0] m, input logic [31:0] s, input int i, input logic [23:0] a);
        case (m)
            2'd0:    return s + i;
            2'd1:    return {8'h0, a};
            2'd2:    return 32'h1 << (i % 32);
            default: return (i % 2 == 0) ? 32'hAAAA_AAAA : 32'h5555_5555;
        endcase
    endfunction

    // expected transaction list and result of a run, from the current stimulus settings
    task automatic build_model(input int aw);
        logic [23:0] a;
        logic [31:0] e, g;
        exp_q.delete();
        exp_err = 0; exp_faddr = 0; exp_fexp = 0; exp_fgot = 0;
        for (int i = 0; i < int'(nw); i++) begin
            a = 24'((32'(ba) + 32'(i) * 4) % (32'h1 << aw));
            exp_q.push_back({1'b1, a, pat(md, sd, i, a)});
        end
        for (int i = 0; i < int'(nw); i++) begin
            a = 24'((32'(ba) + 32'(i) * 4) % (32'h1 << aw));
            e = pat(md, sd, i, a);
            g = (fault_en && a == fault_a) ? (e & ~fault_mask) | (fault_val & fault_mask) : e;
            exp_q.push_back({1'b0, a, 32'h0});
            if (g != e) begin
                if (exp_err == 0) begin exp_faddr = a; exp_fexp = e; exp_fgot = g; end
                exp_err++;
                if (sf) break;
            end
        end
    endtask

    task automatic run(input string tag, input bit use_b, input int hold, input bit ign, input int exp_cyc);
        int   cyc = 0;
        logic d = 0;
        txn_t got_q[$];
        build_model(use_b ? 8 : 24);
        log_q.delete(); log_b.delete(); prot_err = 0;
        force_busy = (hold > 0);
        ba_b = ba[7:0];
        if (use_b) start_b = 1; else start = 1;
        do begin
            @(negedge clk);
            cyc++;
            start_b = 0;
            start = ign && cyc == 3;
            if (ign && cyc == 3) begin sd = ~sd; nw = '0; end
            if (hold > 0 && cyc == hold) begin
                chk({tag, " held_no_stb"}, 64'(log_q.size()), 64'(0));
                chk({tag, " held_busy"}, 64'(busy_o), 64'(1));
                force_busy = 0;
            end
            d = use_b ? done_b : done_o;
        end while (!d && cyc < 4000);
        start = 0;
        chk({tag, " done"}, 64'(d), 64'(1));
        if (exp_cyc > 0) chk({tag, " latency"}, 64'(cyc), 64'(exp_cyc));
        if (use_b) begin
            got_q = log_b;
            chk({tag, " pass"}, 64'(pass_b), 64'(exp_err == 0));
            chk({tag, " err"}, 64'(err_b), 64'(exp_err));
            chk({tag, " faddr"}, 64'(faddr_b), 64'(exp_faddr));
            chk({tag, " fexp"}, 64'(fexp_b), 64'(exp_fexp));
            chk({tag, " fgot"}, 64'(fgot_b), 64'(exp_fgot));
        end else begin
            got_q = log_q;
            chk({tag, " pass"}, 64'(pass_o), 64'(exp_err == 0));
            chk({tag, " err"}, 64'(err_o), 64'(exp_err));
            chk({tag, " faddr"}, 64'(faddr_o), 64'(exp_faddr));
            chk({tag, " fexp"}, 64'(fexp_o), 64'(exp_fexp));
            chk({tag, " fgot"}, 64'(fgot_o), 64'(exp_fgot));
        end
        chk({tag, " ntxn"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk($sformatf("%s txn%0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
        chk({tag, " protocol"}, 64'(prot_err), 64'(0));
        @(negedge clk);
        chk({tag, " done_pulse"}, 64'(use_b ? done_b : done_o), 64'(0));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " busy"}, 64'(busy_o), 64'(0));
        chk({tag, " done"}, 64'(done_o), 64'(0));
        chk({tag, " pass"}, 64'(pass_o), 64'(0));
        chk({tag, " err"}, 64'(err_o), 64'(0));
        chk({tag, " faddr"}, 64'(faddr_o), 64'(0));
        chk({tag, " fexp"}, 64'(fexp_o), 64'(0));
        chk({tag, " fgot"}, 64'(fgot_o), 64'(0));
        chk({tag, " stb"}, 64'(bus.stb), 64'(0));
        chk({tag, " we"}, 64'(bus.we), 64'(0));
        chk({tag, " addr"}, 64'(bus.addr), 64'(0));
        chk({tag, " din"}, 64'(bus.din), 64'(0));
    endtask

    initial begin
        int cyc;
        int rd12;
        #2 rst = 1;
        #2 chk_zero("reset");
        repeat (2) @(negedge clk);
        rst = 0;
        @(negedge clk);

        md = 0; sd = 32'h5555_5555; ba = 0; nw = 4; sf = 0; lat = 3;
        run("incr_basic", 0, 0, 0, 0);

        fault_en = 1; fault_a = 24'h8; fault_mask = 32'h8; fault_val = 32'h8;
        md = 2; nw = 8; sf = 0;
        run("walk1_fault", 0, 0, 0, 0);
        chk("walk1 err", 64'(err_o), 64'(1));
        chk("walk1 faddr", 64'(faddr_o), 64'h8);
        chk("walk1 fexp", 64'(fexp_o), 64'h4);
        chk("walk1 fgot", 64'(fgot_o), 64'hC);

        // 0xAA.. already has bit 3 set, so the mismatch at address 8 comes from bit 3 stuck at 0
        fault_val = 32'h0;
        md = 3; sf = 1;
        run("chk_stop", 0, 0, 0, 0);
        chk("chk_stop fexp", 64'(fexp_o), 64'hAAAA_AAAA);
        rd12 = 0;
        foreach (log_q[i]) if (!log_q[i].we && log_q[i].a == 24'hC) rd12++;
        chk("chk_stop no_read12", 64'(rd12), 64'(0));
        fault_en = 0;

        md = 1; ba = 24'hF8; nw = 4; sf = 0;
        run("wrap8", 1, 0, 0, 0);
        chk("wrap8 third_addr", 64'(log_b.size() > 2 ? log_b[2].a : 24'hFFFFFF), 64'h0);

        ba = 24'hFF_FFF8;
        run("wrap24", 0, 0, 0, 0);

        nw = 0;
        run("zero_words", 0, 0, 0, 1);

        md = 0; ba = 24'h40; nw = 2;
        run("busy_hold", 0, 5, 0, 0);

        md = 1; sd = 32'h1; ba = 24'h200; nw = 5;
        run("ignore_start", 0, 0, 1, 0);

        md = 0; sd = 32'h1234; ba = 24'h100; nw = 8; sf = 0; lat = 2;
        fault_en = 1; fault_a = 24'h100; fault_mask = 32'hFFFF_FFFF; fault_val = 32'h0;
        log_q.delete();
        start = 1;
        @(negedge clk);
        start = 0;
        cyc = 0;
        while (log_q.size() < 11 && cyc < 2000) begin @(negedge clk); cyc++; end
        chk("midrun reached_reads", 64'(log_q.size()), 64'(11));
        chk("midrun err_before", 64'(err_o), 64'(1));
        #2 rst = 1;
        #1 chk_zero("midrun_rst");
        repeat (2) begin
            @(negedge clk);
            chk("midrun no_done", 64'(done_o), 64'(0));
        end
        rst = 0;
        fault_en = 0;
        @(negedge clk);
        run("after_rst", 0, 0, 0, 0);

        for (int r = 0; r < 8; r++) begin
            md = 2'($urandom_range(0, 3));
            sd = $urandom;
            ba = 24'($urandom);
            nw = 20'($urandom_range(1, 12));
            sf = 1'($urandom_range(0, 1));
            lat = $urandom_range(1, 4);
            fault_en = 1'($urandom_range(0, 1));
            fault_a = 24'(32'(ba) + 4 * $urandom_range(0, int'(nw) - 1));
            fault_mask = 32'h1 << $urandom_range(0, 31);
            fault_val = $urandom;
            run($sformatf("rnd%0d", r), 0, 0, 0, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
